// File: rtl/ibex_cheri_cap_mem_seq_if.sv
// Word-wide data port between the capability sequencer (master) and the LSU-side memory (slave).
// Signal names keep the port names of the original block so that traces line up.
interface ibex_cheri_cap_mem_seq_if;
  logic        data_req_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic        data_err_i;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_wtag_o;
  logic [31:0] data_rdata_i;
  logic        data_rtag_i;

  modport master (
    output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o, data_wtag_o,
    input  data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i, data_rtag_i
  );

  modport slave (
    input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o, data_wtag_o,
    output data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i, data_rtag_i
  );
endinterface

// File: rtl/ibex_cheri_cap_mem_seq.sv
// Splits one CAP_W-bit capability load/store into 32-bit word beats on the data port,
// ANDs the per-word tags and reports a single done pulse with data, tag and error status.
module ibex_cheri_cap_mem_seq #(
  parameter int CAP_W = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cap_req_i,
  input  logic                     cap_we_i,
  input  logic [31:0]              cap_addr_i,
  input  logic [CAP_W-1:0]         cap_wdata_i,
  input  logic                     cap_wtag_i,
  output logic                     busy_o,
  output logic                     cap_done_o,
  output logic                     cap_err_o,
  output logic                     cap_misalign_o,
  output logic [CAP_W-1:0]         cap_rdata_o,
  output logic                     cap_rtag_o,
  ibex_cheri_cap_mem_seq_if.master bus
);

  localparam int NUM_BEATS = CAP_W / 32;
  localparam int BEAT_W    = $clog2(NUM_BEATS);
  localparam int ALIGN_W   = $clog2(CAP_W / 8);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  typedef enum logic [1:0] {IDLE, ADDR, RESP, DONE} state_e;

  state_e              state_r, state_s;
  logic [BEAT_W-1:0]   beat_r, beat_s;
  logic                we_r, we_s;
  logic [31:0]         base_r, base_s;
  logic [CAP_W-1:0]    wdata_r, wdata_s;
  logic                wtag_r, wtag_s;
  logic [CAP_W-1:0]    acc_r, acc_s;
  logic                tag_acc_r, tag_acc_s;
  logic                err_r, err_s;
  logic                misalign_r, misalign_s;

  logic                busy_r, done_r, cap_err_r, misalign_out_r, rtag_r;
  logic [CAP_W-1:0]    rdata_r;
  logic                data_req_r, data_we_r, data_wtag_r;
  logic [3:0]          data_be_r;
  logic [31:0]         data_addr_r, data_wdata_r;

  function automatic logic [31:0] beat_offset(input logic [BEAT_W-1:0] beat);
    return {{(30 - BEAT_W){1'b0}}, beat, 2'b00};
  endfunction

  // Next-state and accumulator update for the beat sequencer.
  always_comb begin
    state_s    = state_r;
    beat_s     = beat_r;
    we_s       = we_r;
    base_s     = base_r;
    wdata_s    = wdata_r;
    wtag_s     = wtag_r;
    acc_s      = acc_r;
    tag_acc_s  = tag_acc_r;
    err_s      = err_r;
    misalign_s = misalign_r;
    case (state_r)
      IDLE: begin
        if (cap_req_i) begin
          we_s       = cap_we_i;
          base_s     = cap_addr_i;
          wdata_s    = cap_wdata_i;
          wtag_s     = cap_wtag_i;
          beat_s     = {BEAT_W{1'b0}};
          acc_s      = {CAP_W{1'b0}};
          tag_acc_s  = 1'b1;
          err_s      = 1'b0;
          misalign_s = 1'b0;
          // A misaligned access never touches the bus.
          if (cap_addr_i[ALIGN_W-1:0] == {ALIGN_W{1'b0}}) begin
            state_s = ADDR;
          end else begin
            state_s    = DONE;
            err_s      = 1'b1;
            misalign_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ADDR: begin
        if (bus.data_gnt_i) begin
          state_s = RESP;
        end else begin
          state_s = ADDR;
        end
      end
      RESP: begin
        if (bus.data_rvalid_i) begin
          if (bus.data_err_i) begin
            err_s   = 1'b1;
            state_s = DONE;
          end else begin
            if (!we_r) begin
              acc_s[{beat_r, 5'd0} +: 32] = bus.data_rdata_i;
              tag_acc_s                   = tag_acc_r & bus.data_rtag_i;
            end else begin
              tag_acc_s = tag_acc_r;
            end
            if (beat_r == LAST_BEAT) begin
              state_s = DONE;
            end else begin
              beat_s  = beat_r + 1'b1;
              state_s = ADDR;
            end
          end
        end else begin
          state_s = RESP;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, context and output registers; outputs are decoded from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r        <= IDLE;
      beat_r         <= {BEAT_W{1'b0}};
      we_r           <= 1'b0;
      base_r         <= 32'd0;
      wdata_r        <= {CAP_W{1'b0}};
      wtag_r         <= 1'b0;
      acc_r          <= {CAP_W{1'b0}};
      tag_acc_r      <= 1'b0;
      err_r          <= 1'b0;
      misalign_r     <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      cap_err_r      <= 1'b0;
      misalign_out_r <= 1'b0;
      rdata_r        <= {CAP_W{1'b0}};
      rtag_r         <= 1'b0;
      data_req_r     <= 1'b0;
      data_we_r      <= 1'b0;
      data_wtag_r    <= 1'b0;
      data_be_r      <= 4'b0000;
      data_addr_r    <= 32'd0;
      data_wdata_r   <= 32'd0;
    end else begin
      state_r        <= state_s;
      beat_r         <= beat_s;
      we_r           <= we_s;
      base_r         <= base_s;
      wdata_r        <= wdata_s;
      wtag_r         <= wtag_s;
      acc_r          <= acc_s;
      tag_acc_r      <= tag_acc_s;
      err_r          <= err_s;
      misalign_r     <= misalign_s;
      busy_r         <= (state_s != IDLE);
      done_r         <= (state_s == DONE);
      cap_err_r      <= (state_s == DONE) && err_s;
      misalign_out_r <= (state_s == DONE) && misalign_s;
      // Result is only exposed for a clean load; stores and errors report zero.
      rdata_r        <= ((state_s == DONE) && !err_s && !we_s) ? acc_s : {CAP_W{1'b0}};
      rtag_r         <= (state_s == DONE) && !err_s && !we_s && tag_acc_s;
      data_req_r     <= (state_s == ADDR);
      data_we_r      <= (state_s == ADDR) && we_s;
      data_wtag_r    <= (state_s == ADDR) && we_s && wtag_s;
      data_be_r      <= 4'b1111;
      data_addr_r    <= (state_s == ADDR) ? (base_s + beat_offset(beat_s)) : 32'd0;
      data_wdata_r   <= (state_s == ADDR) ? wdata_s[{beat_s, 5'd0} +: 32] : 32'd0;
    end
  end

  assign busy_o           = busy_r;
  assign cap_done_o       = done_r;
  assign cap_err_o        = cap_err_r;
  assign cap_misalign_o   = misalign_out_r;
  assign cap_rdata_o      = rdata_r;
  assign cap_rtag_o       = rtag_r;
  assign bus.data_req_o   = data_req_r;
  assign bus.data_we_o    = data_we_r;
  assign bus.data_be_o    = data_be_r;
  assign bus.data_addr_o  = data_addr_r;
  assign bus.data_wdata_o = data_wdata_r;
  assign bus.data_wtag_o  = data_wtag_r;

endmodule
